// File: rtl/rv32f_rf_pkg.sv
// Shared types and constants for the RV32F register file with scoreboard.
// Used by rv32f_rf_scoreboard and rv32f_reg_file_sb.
package rv32f_rf_pkg;

  localparam logic [31:0] RESET_VAL = 32'h7fc00000;

  typedef struct packed {
    logic nv;
    logic dz;
    logic of;
    logic uf;
    logic nx;
  } fflags_t;

  function automatic int rf_aw(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/rv32f_rf_scoreboard.sv
// Pending-bit scoreboard: reserve/clear/flush priority, grant and per-port busy lookup.
// Optional same-cycle busy bypass under RV32F_RF_BYPASS_EN.
module rv32f_rf_scoreboard
  import rv32f_rf_pkg::*;
#(
  parameter int NUM_REGS = 32,
  parameter int NUM_RD   = 3,
  parameter int AW       = rf_aw(NUM_REGS)
) (
  input  logic                 clk,
  input  logic                 n_rst,
  input  logic [NUM_RD*AW-1:0] rs_addr,
  input  logic                 rsv_en,
  input  logic [AW-1:0]        rsv_addr,
  input  logic                 wa_en,
  input  logic [AW-1:0]        wa_addr,
  input  logic                 wb_acc,
  input  logic [AW-1:0]        wb_addr,
  input  logic                 flush,
  output logic                 rsv_gnt,
  output logic [NUM_RD-1:0]    rs_busy
);

  logic [NUM_REGS-1:0] pend_q, pend_d;

  assign rsv_gnt = rsv_en & ~pend_q[rsv_addr] & ~flush;

  // Reservation is newer than any same-cycle writeback; flush beats everything.
  always_comb begin
    pend_d = pend_q;
    if (wa_en)   pend_d[wa_addr]  = 1'b0;
    if (wb_acc)  pend_d[wb_addr]  = 1'b0;
    if (rsv_gnt) pend_d[rsv_addr] = 1'b1;
    if (flush)   pend_d           = '0;
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) pend_q <= '0;
    else        pend_q <= pend_d;
  end

  for (genvar g = 0; g < NUM_RD; g++) begin : g_busy
    logic [AW-1:0] a;
    logic          busy;
    assign a = rs_addr[g*AW +: AW];
    always_comb begin
      busy = pend_q[a];
`ifdef RV32F_RF_BYPASS_EN
      if ((wa_en && wa_addr == a) || (wb_acc && wb_addr == a))
        busy = rsv_gnt && (rsv_addr == a);
`endif
    end
    assign rs_busy[g] = busy;
  end

endmodule

// File: rtl/rv32f_reg_file_sb.sv
// FP register file with dual writeback, WAW/RAW scoreboard and sticky fflags.
// Define RV32F_RF_BYPASS_EN to forward same-cycle write data to the read ports.
module rv32f_reg_file_sb
  import rv32f_rf_pkg::*;
#(
  parameter  int NUM_REGS = 32,
  parameter  int DATA_W   = 32,
  parameter  int NUM_RD   = 3,
  localparam int AW       = rf_aw(NUM_REGS)
) (
  input  logic                     clk,
  input  logic                     n_rst,
  input  logic [NUM_RD*AW-1:0]     rs_addr,
  output logic [NUM_RD*DATA_W-1:0] rs_data,
  output logic [NUM_RD-1:0]        rs_busy,
  input  logic                     rsv_en,
  input  logic [AW-1:0]            rsv_addr,
  output logic                     rsv_gnt,
  input  logic                     wa_en,
  input  logic [AW-1:0]            wa_addr,
  input  logic [DATA_W-1:0]        wa_data,
  input  logic [4:0]               wa_flags,
  input  logic                     wb_en,
  input  logic [AW-1:0]            wb_addr,
  input  logic [DATA_W-1:0]        wb_data,
  output logic                     wb_stall,
  input  logic                     flush,
  output logic [4:0]               fflags,
  input  logic                     fflags_clr
);

  logic [DATA_W-1:0] regs_q [NUM_REGS];
  fflags_t           fflags_q, fflags_d, ff_base;
  logic              wb_acc;

  // Port A always wins a same-address collision; the load path retries.
  assign wb_stall = wb_en & wa_en & (wa_addr == wb_addr);
  assign wb_acc   = wb_en & ~wb_stall;

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      for (int i = 0; i < NUM_REGS; i++) regs_q[i] <= DATA_W'(RESET_VAL);
    end else begin
      if (wa_en)  regs_q[wa_addr] <= wa_data;
      if (wb_acc) regs_q[wb_addr] <= wb_data;
    end
  end

  always_comb begin
    ff_base  = fflags_clr ? '0 : fflags_q;
    fflags_d = fflags_t'(ff_base | (wa_flags & {5{wa_en}}));
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) fflags_q <= '0;
    else        fflags_q <= fflags_d;
  end

  assign fflags = fflags_q;

  for (genvar g = 0; g < NUM_RD; g++) begin : g_rd
    logic [AW-1:0]     a;
    logic [DATA_W-1:0] d;
    assign a = rs_addr[g*AW +: AW];
    always_comb begin
      d = regs_q[a];
`ifdef RV32F_RF_BYPASS_EN
      if (wa_en && wa_addr == a)       d = wa_data;
      else if (wb_acc && wb_addr == a) d = wb_data;
`endif
    end
    assign rs_data[g*DATA_W +: DATA_W] = d;
  end

  rv32f_rf_scoreboard #(
    .NUM_REGS (NUM_REGS),
    .NUM_RD   (NUM_RD),
    .AW       (AW)
  ) u_sb (
    .clk      (clk),
    .n_rst    (n_rst),
    .rs_addr  (rs_addr),
    .rsv_en   (rsv_en),
    .rsv_addr (rsv_addr),
    .wa_en    (wa_en),
    .wa_addr  (wa_addr),
    .wb_acc   (wb_acc),
    .wb_addr  (wb_addr),
    .flush    (flush),
    .rsv_gnt  (rsv_gnt),
    .rs_busy  (rs_busy)
  );

endmodule

// File: tb/tb_rv32f_reg_file_sb.sv
// Directed and randomized bench for rv32f_reg_file_sb against an array-based reference model.
module tb_rv32f_reg_file_sb;

  localparam int NR = 32;
  localparam int AW = 5;
  localparam int NP = 3;
  localparam logic [31:0] NAN = 32'h7fc00000;

  logic          clk = 1'b0;
  logic          n_rst;
  logic [AW-1:0] rd_a [NP];
  logic [NP*AW-1:0] rs_addr;
  logic [NP*32-1:0] rs_data;
  logic [NP-1:0] rs_busy;
  logic          rsv_en, rsv_gnt, wa_en, wb_en, wb_stall, flush, fflags_clr;
  logic [AW-1:0] rsv_addr, wa_addr, wb_addr;
  logic [31:0]   wa_data, wb_data;
  logic [4:0]    wa_flags, fflags;

  logic [31:0] m_reg [NR];
  bit          m_pend [NR];
  logic [4:0]  m_ff;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;
  assign rs_addr = {rd_a[2], rd_a[1], rd_a[0]};

  rv32f_reg_file_sb dut (
    .clk(clk), .n_rst(n_rst), .rs_addr(rs_addr), .rs_data(rs_data), .rs_busy(rs_busy),
    .rsv_en(rsv_en), .rsv_addr(rsv_addr), .rsv_gnt(rsv_gnt),
    .wa_en(wa_en), .wa_addr(wa_addr), .wa_data(wa_data), .wa_flags(wa_flags),
    .wb_en(wb_en), .wb_addr(wb_addr), .wb_data(wb_data), .wb_stall(wb_stall),
    .flush(flush), .fflags(fflags), .fflags_clr(fflags_clr)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic idle();
    rsv_en = 0; rsv_addr = '0; wa_en = 0; wa_addr = '0; wa_data = '0; wa_flags = '0;
    wb_en = 0; wb_addr = '0; wb_data = '0; flush = 0; fflags_clr = 0;
  endtask

  task automatic model_reset();
    for (int i = 0; i < NR; i++) begin m_reg[i] = NAN; m_pend[i] = 0; end
    m_ff = '0;
  endtask

  // Compare every output against what the model predicts for the current inputs.
  task automatic settle();
    bit gnt, stall, bz;
    logic [31:0] d;
    #4;
    gnt   = rsv_en && !flush && !m_pend[rsv_addr];
    stall = wb_en && wa_en && (wa_addr == wb_addr);
    chk("rsv_gnt", 32'(rsv_gnt), 32'(gnt));
    chk("wb_stall", 32'(wb_stall), 32'(stall));
    chk("fflags", 32'(fflags), 32'(m_ff));
    for (int i = 0; i < NP; i++) begin
      d  = m_reg[rd_a[i]];
      bz = m_pend[rd_a[i]];
`ifdef RV32F_RF_BYPASS_EN
      if (wa_en && wa_addr == rd_a[i]) begin
        d = wa_data; bz = gnt && rsv_addr == rd_a[i];
      end else if (wb_en && !stall && wb_addr == rd_a[i]) begin
        d = wb_data; bz = gnt && rsv_addr == rd_a[i];
      end
`endif
      chk($sformatf("rd%0d_data", i), rs_data[i*32 +: 32], d);
      chk($sformatf("rd%0d_busy", i), 32'(rs_busy[i]), 32'(bz));
    end
  endtask

  task automatic tick();
    bit gnt, stall;
    gnt   = rsv_en && !flush && !m_pend[rsv_addr];
    stall = wb_en && wa_en && (wa_addr == wb_addr);
    if (wa_en) begin m_reg[wa_addr] = wa_data; m_pend[wa_addr] = 0; end
    if (wb_en && !stall) begin m_reg[wb_addr] = wb_data; m_pend[wb_addr] = 0; end
    if (gnt) m_pend[rsv_addr] = 1;
    if (flush) for (int i = 0; i < NR; i++) m_pend[i] = 0;
    m_ff = (fflags_clr ? 5'b0 : m_ff) | (wa_en ? wa_flags : 5'b0);
    @(posedge clk);
    #1;
  endtask

  initial begin
    n_rst = 0;
    idle();
    rd_a[0] = 5'd0; rd_a[1] = 5'd5; rd_a[2] = 5'd31;
    model_reset();
    @(posedge clk); #1;
    n_rst = 1;

    // Reset state
    settle();
    for (int i = 0; i < NP; i++) chk($sformatf("rst_data%0d", i), rs_data[i*32 +: 32], NAN);
    chk("rst_busy", 32'(rs_busy), 32'd0);
    chk("rst_fflags", 32'(fflags), 32'd0);
    tick();

    // Reserve f3, re-reserve is refused, port A write clears it
    idle(); rsv_en = 1; rsv_addr = 5'd3; rd_a[0] = 5'd3;
    settle(); chk("rsv_f3_gnt", 32'(rsv_gnt), 32'd1); tick();
    idle(); rsv_en = 1; rsv_addr = 5'd3;
    settle(); chk("rsv_f3_again", 32'(rsv_gnt), 32'd0); chk("f3_busy", 32'(rs_busy[0]), 32'd1); tick();
    idle(); wa_en = 1; wa_addr = 5'd3; wa_data = 32'h3f800000; wa_flags = 5'b00001;
    settle(); tick();
    idle();
    settle();
    chk("f3_data", rs_data[31:0], 32'h3f800000);
    chk("f3_busy_clr", 32'(rs_busy[0]), 32'd0);
    chk("fflags_nx", 32'(fflags), 32'h01);
    tick();

    // Same-address A/B conflict on f7
    idle(); rd_a[0] = 5'd7;
    wa_en = 1; wa_addr = 5'd7; wa_data = 32'h40000000;
    wb_en = 1; wb_addr = 5'd7; wb_data = 32'h40400000;
    settle(); chk("f7_stall", 32'(wb_stall), 32'd1); tick();
    idle(); settle(); chk("f7_a_wins", rs_data[31:0], 32'h40000000);
    wb_en = 1; wb_addr = 5'd7; wb_data = 32'h40400000;
    settle(); chk("f7_retry_nostall", 32'(wb_stall), 32'd0); tick();
    idle(); settle(); chk("f7_b_done", rs_data[31:0], 32'h40400000); tick();

    // Write and reserve f9 together, then flush with a competing reservation
    idle(); rd_a[0] = 5'd9;
    wa_en = 1; wa_addr = 5'd9; wa_data = 32'h12345678; rsv_en = 1; rsv_addr = 5'd9;
    settle(); tick();
    idle(); settle();
    chk("f9_data", rs_data[31:0], 32'h12345678);
    chk("f9_busy", 32'(rs_busy[0]), 32'd1);
    flush = 1; rsv_en = 1; rsv_addr = 5'd10;
    settle(); chk("flush_gnt", 32'(rsv_gnt), 32'd0); tick();
    idle(); rd_a[1] = 5'd10; rd_a[2] = 5'd3;
    settle(); chk("flush_busy", 32'(rs_busy), 32'd0); tick();

    // Read of f4 during its write: forwarded only in the bypass build
    idle(); rd_a[0] = 5'd4; wa_en = 1; wa_addr = 5'd4; wa_data = 32'hc0a00000;
    settle();
`ifdef RV32F_RF_BYPASS_EN
    chk("f4_bypass", rs_data[31:0], 32'hc0a00000);
`else
    chk("f4_nobypass", rs_data[31:0], NAN);
`endif
    tick();

    // Clear-then-accumulate when fflags_clr meets a port A write
    idle(); wa_en = 1; wa_addr = 5'd12; wa_data = 32'h1; wa_flags = 5'b00100; fflags_clr = 1;
    settle(); tick();
    idle(); settle(); chk("fflags_clr_wa", 32'(fflags), 32'h04); tick();

    // Randomized traffic over a small address window to force collisions
    for (int n = 0; n < 400; n++) begin
      idle();
      rsv_en = ($urandom_range(0, 2) == 0); rsv_addr = 5'($urandom_range(0, 7));
      wa_en = ($urandom_range(0, 2) == 0); wa_addr = 5'($urandom_range(0, 7));
      wa_data = $urandom; wa_flags = 5'($urandom);
      wb_en = ($urandom_range(0, 2) == 0); wb_addr = 5'($urandom_range(0, 7));
      wb_data = $urandom;
      flush = ($urandom_range(0, 15) == 0);
      fflags_clr = ($urandom_range(0, 11) == 0);
      for (int i = 0; i < NP; i++) rd_a[i] = 5'($urandom_range(0, 7));
      settle();
      tick();
    end

    // Asynchronous reset mid-stream with f1/f2 pending and fflags = NV
    idle(); flush = 1; settle(); tick();
    idle(); rsv_en = 1; rsv_addr = 5'd1; settle(); tick();
    idle(); rsv_en = 1; rsv_addr = 5'd2; settle(); tick();
    idle(); wa_en = 1; wa_addr = 5'd20; wa_data = 32'hdeadbeef; wa_flags = 5'b10000; fflags_clr = 1;
    settle(); tick();
    idle(); rd_a[0] = 5'd1; rd_a[1] = 5'd2; rd_a[2] = 5'd20;
    settle();
    chk("pre_rst_busy", 32'(rs_busy), 32'h3);
    chk("pre_rst_fflags", 32'(fflags), 32'h10);
    wa_en = 1; wa_addr = 5'd21; wa_data = 32'h0; rsv_en = 1; rsv_addr = 5'd5;
    n_rst = 0;
    #1;
    chk("rst_fflags_now", 32'(fflags), 32'd0);
    for (int j = 0; j < NR; j += NP) begin
      for (int i = 0; i < NP; i++) rd_a[i] = 5'((j + i) % NR);
      #1;
      for (int i = 0; i < NP; i++) begin
        chk($sformatf("rst_reg%0d", (j + i) % NR), rs_data[i*32 +: 32], NAN);
        chk($sformatf("rst_pend%0d", (j + i) % NR), 32'(rs_busy[i]), 32'd0);
      end
    end
    idle();
    model_reset();
    @(posedge clk); #1;
    n_rst = 1;
    rd_a[0] = 5'd1; rd_a[1] = 5'd2; rd_a[2] = 5'd21;
    settle();
    tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/rv32f_reg_file_sb.md
# rv32f_reg_file_sb

Parametrised floating-point register file with an integrated write-after-write/read-after-write scoreboard, dual write ports and sticky exception-flag accumulation. It sits between FPU issue logic and the FPU/load writeback paths. It supplies up to NUM_RD operands per cycle, which covers rs3 for fused multiply-add. It also tracks which registers await a multi-cycle result, so issue can stall without a separate hazard unit.

## Interface
- NUM_REGS, 32, number of FP registers; power of two; AW = $clog2(NUM_REGS)
- DATA_W, 32, register width
- NUM_RD, 3, number of read ports
- clk  input  1  clock; all state updates on rising edge
- n_rst  input  1  asynchronous reset, active-low
- rs_addr  input  NUM_RD*AW  read addresses, port i at bits [i*AW +: AW]
- rs_data  output  NUM_RD*DATA_W  read data per port
- rs_busy  output  NUM_RD  pending bit of each addressed register
- rsv_en  input  1  reserve destination for a multi-cycle op
- rsv_addr  input  AW  register to reserve
- rsv_gnt  output  1  rsv_en & ~pending[rsv_addr]
- wa_en, wa_addr, wa_data  input  1, AW, DATA_W  FPU writeback (port A)
- wa_flags  input  5  NV/DZ/OF/UF/NX of the port A result
- wb_en, wb_addr, wb_data  input  1, AW, DATA_W  load writeback (port B)
- wb_stall  output  1  port B write not accepted this cycle
- flush  input  1  clear all pending bits
- fflags  output  5  sticky accumulated exception flags
- fflags_clr  input  1  clear fflags (CSR write)

## Operation
- Reset: all registers = canonical NaN 32'h7fc00000 (zero-extended if DATA_W>32), pending = 0, fflags = 0. Outputs after reset: rs_data = RESET_VAL on every port, rs_busy = 0, rsv_gnt = rsv_en, wb_stall = 0.
- Read: combinational, rs_data[i] = reg[rs_addr[i]]; rs_busy[i] = pending[rs_addr[i]].
- Reserve: if rsv_gnt, set pending[rsv_addr] at the next edge. If rsv_en and the register is already pending, rsv_gnt = 0, no change, and the requester holds.
- Port A write: reg[wa_addr] <= wa_data; pending[wa_addr] <= 0; fflags <= fflags | wa_flags.
- Port B write: accepted when ~(wa_en & wa_addr==wb_addr). On accept: reg[wb_addr] <= wb_data, pending[wb_addr] <= 0.
  - On a same-address conflict, wb_stall = 1 (combinational), port B is dropped, and the source re-presents it next cycle. Port A is never stalled.
  - Different-address A and B writes both complete in the same cycle.
- Reserve and write to the same address in one cycle: the write updates data, and pending ends at 1 because the reservation is newer.
- flush: all pending <= 0. It overrides a same-cycle reservation, and rsv_gnt is forced to 0 while flush = 1. Same-cycle writes still update data.
- fflags_clr together with wa_en: fflags <= wa_flags, so the clear applies first.

## Timing
- Read latency: 0 cycles (combinational).
- Write, pending and fflags updates are visible on the cycle after the edge.
- rsv_gnt and wb_stall are combinational from the same-cycle inputs. No registered handshake state.
- Asynchronous reset mid-operation abandons in-flight writes and reservations immediately.

## Configuration
- RV32F_RF_BYPASS_EN defined:
  - A read of an address being written this cycle returns the incoming data (port A first, then an accepted port B).
  - rs_busy for that port = 0 unless a same-cycle reservation targets it.
- Not defined: reads return the pre-write value, rs_busy reflects the registered pending bit, and the consumer waits one cycle.

## Structure
- Shared package rv32f_rf_pkg: RESET_VAL constant 32'h7fc00000, fflags_t packed struct {nv,dz,of,uf,nx}, and the AW localparam function.
- Sub-module rv32f_rf_scoreboard: pending vector, reserve/clear/flush priority, rsv_gnt, and the rs_busy lookup. The top level holds the data array, write arbitration, bypass muxes and fflags.

## Test plan
- Reset then read ports 0..2 at addrs 0, 5, 31 -> all rs_data = 32'h7fc00000, rs_busy = 0, fflags = 0.
- Reserve f3, then rsv_en f3 again next cycle -> rsv_gnt = 0. Port A writes f3 = 32'h3f800000 with wa_flags = 5'b00001 -> pending cleared, read = 32'h3f800000, fflags = 5'b00001.
- Port A and B both write f7 in the same cycle (A = 32'h40000000, B = 32'h40400000) -> wb_stall = 1, f7 = 32'h40000000. B re-presented next cycle -> f7 = 32'h40400000.
- Same-cycle port A write f9 and rsv_en f9 -> f9 holds the new data and rs_busy for f9 = 1. flush + rsv_en f10 -> rsv_gnt = 0, all pending = 0.
- Bypass: port A writes f4 = 32'hc0a00000 while rs_addr[0] = f4 -> rs_data[0] = 32'hc0a00000 same cycle with macro; old value without it.
- Assert n_rst mid-stream with pending f1, f2 and fflags = 5'b10000 -> all registers = NaN, pending = 0, fflags = 0 immediately.
